// File: rtl/abcd_vector_sequencer.sv
// Gray-code stimulus source and truth-table capture for a 4-input logic block.
// Each vector is held for HOLD_CYCLES, G is sampled once, and a 16-entry table is built.
module abcd_vector_sequencer #(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        step_mode,
   input  logic        step,
   input  logic        g_in,
   output logic        a_out,
   output logic        b_out,
   output logic        c_out,
   output logic        d_out,
   output logic [3:0]  idx,
   output logic [15:0] truth,
   output logic [4:0]  g_count,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] hold_cnt;
   logic [3:0]       vec;
   logic [3:0]       next_idx;

   function automatic logic [3:0] to_gray(input logic [3:0] v);
      return v ^ (v >> 1);
   endfunction

   assign next_idx = idx + 4'd1;
   assign {a_out, b_out, c_out, d_out} = vec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         hold_cnt <= '0;
         idx      <= '0;
         vec      <= '0;
         truth    <= '0;
         g_count  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state    <= S_DRIVE;
                  hold_cnt <= '0;
                  idx      <= '0;
                  vec      <= '0;
                  truth    <= '0;
                  g_count  <= '0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
               end
            end
            S_DRIVE: begin
               // The vector was loaded on entry, so HOLD_CYCLES cycles here give the settle time.
               if (hold_cnt == HOLD_LAST) begin
                  state <= S_SAMPLE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            S_SAMPLE: begin
               truth[vec] <= g_in;
               g_count    <= g_count + {4'b0000, g_in};
               if (idx == 4'd15) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (step_mode) begin
                  state <= S_WAIT;
               end else begin
                  state    <= S_DRIVE;
                  hold_cnt <= '0;
                  idx      <= next_idx;
                  vec      <= to_gray(next_idx);
               end
            end
            S_WAIT: begin
               // Dropping step_mode releases the pause just like a step pulse.
               if (step || !step_mode) begin
                  state    <= S_DRIVE;
                  hold_cnt <= '0;
                  idx      <= next_idx;
                  vec      <= to_gray(next_idx);
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_abcd_vector_sequencer.sv
// Randomized bench for abcd_vector_sequencer: free-run sweeps, step mode and async reset,
// compared against a cycle-count and lookup-table model of the sweep.
module tb_abcd_vector_sequencer;

   localparam int H1 = 4;
   localparam int H2 = 2;

   logic clk;
   logic rst;

   logic        start1, step_mode1, step1, g1;
   logic        a1, b1, c1, d1, busy1, done1;
   logic [3:0]  idx1;
   logic [15:0] truth1;
   logic [4:0]  gcnt1;

   logic        start2, step_mode2, step2, g2;
   logic        a2, b2, c2, d2, busy2, done2;
   logic [3:0]  idx2;
   logic [15:0] truth2;
   logic [4:0]  gcnt2;

   logic [15:0] tt1, tt2;
   logic [3:0]  vec1, vec2;
   logic [3:0]  gseq [16];

   int n_checks;
   int n_errors;

   assign vec1 = {a1, b1, c1, d1};
   assign vec2 = {a2, b2, c2, d2};
   assign g1   = tt1[vec1];
   assign g2   = tt2[vec2];

   abcd_vector_sequencer #(.HOLD_CYCLES(H1), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .start(start1), .step_mode(step_mode1), .step(step1),
      .g_in(g1), .a_out(a1), .b_out(b1), .c_out(c1), .d_out(d1), .idx(idx1),
      .truth(truth1), .g_count(gcnt1), .busy(busy1), .done(done1)
   );

   abcd_vector_sequencer #(.HOLD_CYCLES(H2), .CNT_W(8)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .step_mode(step_mode2), .step(step2),
      .g_in(g2), .a_out(a2), .b_out(b2), .c_out(c2), .d_out(d2), .idx(idx2),
      .truth(truth2), .g_count(gcnt2), .busy(busy2), .done(done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int popcnt(input logic [15:0] v);
      int n = 0;
      for (int i = 0; i < 16; i++) n += v[i];
      return n;
   endfunction

   // G = A'D' + ABD + B'D' + ACD evaluated for every vector value.
   function automatic logic [15:0] eq_table();
      logic [15:0] t;
      logic a, b, c, d;
      t = '0;
      for (int n = 0; n < 16; n++) begin
         a = n[3]; b = n[2]; c = n[1]; d = n[0];
         t[n] = (!a && !d) || (a && b && d) || (!b && !d) || (a && c && d);
      end
      return t;
   endfunction

   task automatic sweep1(input logic [15:0] tt, input logic [15:0] exp_truth,
                         input int exp_cnt, input bit inject);
      int per, total, ei, done_at;
      per     = H1 + 1;
      total   = 16 * per;
      done_at = -1;
      tt1     = tt;
      start1  = 1'b1;
      for (int k = 0; k < total + 10; k++) begin
         tick();
         start1 = 1'b0;
         step1  = 1'b0;
         ei = (k / per > 15) ? 15 : k / per;
         if (k == 0) begin
            check("truth_clr", truth1, 0);
            check("gcnt_clr", gcnt1, 0);
         end
         check("idx", idx1, ei);
         check("vec", vec1, gseq[ei]);
         check("busy", busy1, k < total);
         check("done", done1, k >= total);
         if (done1 && done_at < 0) done_at = k + 1;
         if (inject && k == 5 * per) start1 = 1'b1;
         step1 = 1'($urandom_range(0, 1));
      end
      step1 = 1'b0;
      check("latency", done_at, 1 + 16 * (H1 + 1));
      check("truth", truth1, exp_truth);
      check("gcnt", gcnt1, exp_cnt);
   endtask

   task automatic step_test();
      int extra;
      step_mode2 = 1'b1;
      tt2        = 16'($urandom);
      start2     = 1'b1;
      tick();
      start2 = 1'b0;
      check("s_idx0", idx2, 0);
      check("s_vec0", vec2, 0);
      check("s_busy0", busy2, 1);
      for (int i = 0; i < 16; i++) begin
         repeat (H2 + 1) tick();
         if (i == 15) begin
            check("s_done", done2, 1);
            check("s_busy_end", busy2, 0);
            check("s_idx_end", idx2, 15);
         end else begin
            extra = $urandom_range(1, 4);
            repeat (extra) begin
               check("s_wait_idx", idx2, i);
               check("s_wait_vec", vec2, gseq[i]);
               check("s_wait_busy", busy2, 1);
               check("s_wait_done", done2, 0);
               start2 = ($urandom_range(0, 2) == 0);
               tick();
               start2 = 1'b0;
            end
            check("s_hold_idx", idx2, i);
            if (i == 7) step_mode2 = 1'b0;
            else        step2      = 1'b1;
            tick();
            step2      = 1'b0;
            step_mode2 = 1'b1;
            check("s_step_idx", idx2, i + 1);
         end
      end
      check("s_truth", truth2, tt2);
      check("s_gcnt", gcnt2, popcnt(tt2));
   endtask

   task automatic reset_test();
      tt1    = 16'hFFFF;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int k = 1; k <= 7 * (H1 + 1); k++) tick();
      check("r_idx7", idx1, 7);
      check("r_gcnt7", gcnt1, 7);
      #2;
      rst = 1'b1;
      #1;
      check("r_idx", idx1, 0);
      check("r_vec", vec1, 0);
      check("r_truth", truth1, 0);
      check("r_gcnt", gcnt1, 0);
      check("r_busy", busy1, 0);
      check("r_done", done1, 0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check("r_idle_busy", busy1, 0);
      check("r_idle_idx", idx1, 0);
      check("r_idle_truth", truth1, 0);
   endtask

   initial begin
      logic [15:0] r;
      gseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
               4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
      n_checks   = 0;
      n_errors   = 0;
      rst        = 1'b1;
      start1     = 1'b0; step_mode1 = 1'b0; step1 = 1'b0;
      start2     = 1'b0; step_mode2 = 1'b0; step2 = 1'b0;
      tt1        = '0;
      tt2        = '0;
      repeat (2) tick();
      check("rst_idx", idx1, 0);
      check("rst_vec", vec1, 0);
      check("rst_truth", truth1, 0);
      check("rst_gcnt", gcnt1, 0);
      check("rst_busy", busy1, 0);
      check("rst_done", done1, 0);
      check("rst_idx2", idx2, 0);
      check("rst_busy2", busy2, 0);
      rst = 1'b0;
      tick();

      sweep1(eq_table(), 16'hAD55, 9, 1'b0);
      sweep1(16'h0000, 16'h0000, 0, 1'b1);
      sweep1(16'hFFFF, 16'hFFFF, 16, 1'b0);
      for (int n = 0; n < 4; n++) begin
         r = 16'($urandom);
         sweep1(r, r, popcnt(r), 1'b1);
      end

      step_test();
      reset_test();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
